// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide,
// HI/LO result registers with MTHI/MTLO write ports.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wd_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [1:0]       state_o
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_sub;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;

    // Signed ops work on magnitudes; the most negative value maps to itself,
    // which is still the correct unsigned magnitude.
    assign a_neg = op_i[0] & a_i[WIDTH-1];
    assign b_neg = op_i[0] & b_i[WIDTH-1];
    assign abs_a = a_neg ? -a_i : a_i;
    assign abs_b = b_neg ? -b_i : b_i;

    // Multiply: acc:work holds partial product, multiplier bits shift out of work.
    assign mul_sum = {1'b0, acc_q} + (work_q[0] ? {1'b0, m_q} : '0);

    // Divide: acc is the partial remainder, quotient bits shift into work.
    assign div_sh  = {acc_q, work_q[WIDTH-1]};
    assign div_ge  = div_sh >= {1'b0, m_q};
    assign div_sub = div_sh - {1'b0, m_q};

    assign prod     = {acc_q, work_q};
    assign prod_fix = neg_lo_q ? -prod : prod;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        work_d   = work_q;
        m_d      = m_q;
        a_d      = a_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hi_we_i) hi_d = wd_i;
                if (lo_we_i) lo_d = wd_i;
                if (start_i) begin
                    state_d  = S_CALC;
                    cnt_d    = CW'(WIDTH);
                    op_d     = op_i;
                    a_d      = a_i;
                    acc_d    = '0;
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    if (op_i[1]) begin
                        work_d = abs_a;
                        m_d    = abs_b;
                    end else begin
                        work_d = abs_b;
                        m_d    = abs_a;
                    end
                end
            end
            S_CALC: begin
                if (op_q[1]) begin
                    if (div_ge) begin
                        acc_d  = div_sub[WIDTH-1:0];
                        work_d = {work_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d  = div_sh[WIDTH-1:0];
                        work_d = {work_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d  = mul_sum[WIDTH:1];
                    work_d = {mul_sum[0], work_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    if (m_q == '0) begin
                        hi_d  = a_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = neg_lo_q ? -work_q : work_q;
                        hi_d = neg_hi_q ? -acc_q : acc_q;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            work_q   <= '0;
            m_q      <= '0;
            a_q      <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            work_q   <= work_d;
            m_q      <= m_d;
            a_q      <= a_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign state_o       = state_q;
endmodule
